// File: rtl/img_src_ctrl.sv
// Image source controller: reads pixels from a byte source in raster order and
// streams them through a 4-entry skid FIFO with sof/eol sideband.
//
// state | meaning
// IDLE  | waiting for start
// LINE  | issuing source reads for the current line
// HGAP  | idle gap between lines
// DRAIN | waiting for FIFO and in-flight read to empty, then frame_done
// VGAP  | idle gap between frames in continuous mode
module img_src_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int H_GAP      = 16,
    parameter int V_GAP      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  busy,
    output logic                  src_rd_en,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  frame_done
);

    typedef enum logic [2:0] {IDLE, LINE, HGAP, DRAIN, VGAP} state_t;

    localparam logic [11:0] X_LAST = 12'(IMG_W - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_H - 1);
    localparam logic [15:0] H_LOAD = (H_GAP > 0) ? 16'(H_GAP - 1) : 16'd0;
    // The frame_done cycle is the first idle cycle of the inter-frame gap.
    localparam logic [15:0] V_LOAD = (V_GAP > 1) ? 16'(V_GAP - 2) : 16'd0;

    state_t state, state_nxt;

    logic [11:0] x, y;
    logic [15:0] gap_cnt;
    logic        in_flight, tag_sof, tag_eol;
    logic        x_last, y_last, gap_done;

    logic [DATA_WIDTH+1:0] fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_cnt;
    logic                  wr_en, pop;

    assign x_last   = (x == X_LAST);
    assign y_last   = (y == Y_LAST);
    assign gap_done = (gap_cnt == 16'd0);
    assign busy     = (state != IDLE);

    // Beats returning after a reset have no matching read and are dropped.
    assign wr_en   = src_valid && in_flight;
    assign m_valid = (fifo_cnt != 3'd0);
    assign pop     = m_valid && m_ready;
    assign {m_data, m_sof, m_eol} = m_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        src_rd_en  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LINE;
            end
            LINE: begin
                src_rd_en = (fifo_cnt + {2'b00, in_flight}) < 3'd4;
                if (src_rd_en && x_last) state_nxt = y_last ? DRAIN : HGAP;
            end
            HGAP: begin
                if (gap_done) state_nxt = LINE;
            end
            DRAIN: begin
                if (!m_valid && !in_flight) begin
                    frame_done = 1'b1;
                    state_nxt  = continuous ? VGAP : IDLE;
                end
            end
            VGAP: begin
                if (gap_done) state_nxt = LINE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            gap_cnt   <= '0;
            in_flight <= 1'b0;
            tag_sof   <= 1'b0;
            tag_eol   <= 1'b0;
        end else begin
            in_flight <= src_rd_en;
            if (src_rd_en) begin
                tag_sof <= (x == 12'd0) && (y == 12'd0);
                tag_eol <= x_last;
                x       <= x_last ? 12'd0 : x + 12'd1;
                gap_cnt <= H_LOAD;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        x <= '0;
                        y <= '0;
                    end
                end
                HGAP: begin
                    if (gap_done) y <= y + 12'd1;
                    else          gap_cnt <= gap_cnt - 16'd1;
                end
                DRAIN: gap_cnt <= V_LOAD;
                VGAP: begin
                    if (gap_done) begin
                        x <= '0;
                        y <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= {src_data, tag_sof, tag_eol};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_img_src_ctrl.sv
// Scoreboard bench for img_src_ctrl: a source model pushes expected pixels as it
// returns random data; a monitor pops and compares on every accepted pixel.
module tb_img_src_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HG   = 2;
    localparam int VG   = 3;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       busy, src_rd_en;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'd0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_sof, m_eol, frame_done;

    img_src_ctrl #(
        .DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .H_GAP(HG), .V_GAP(VG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .busy(busy), .src_rd_en(src_rd_en), .src_valid(src_valid),
        .src_data(src_data), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [9:0] exp_q[$];
    int rd_cyc_q[$];
    int pix_idx = 0;
    int reads_total = 0;
    int xfer_total = 0;
    int fd_count = 0;
    int fd_cyc = 0;
    int last_xfer_cyc = 0;
    int frame_pix = 0;
    int frame_sof = 0;
    int frame_eol = 0;
    int ready_mode = 0;
    logic pend = 1'b0;
    logic hold_pending = 1'b0;
    logic [9:0] held = '0;
    logic [9:0] exp_e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_src_rd_en"},  int'(src_rd_en), 0);
        check({tag, "_m_valid"},    int'(m_valid), 0);
        check({tag, "_m_sof"},      int'(m_sof), 0);
        check({tag, "_m_eol"},      int'(m_eol), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_m_data"},     int'(m_data), 0);
    endtask

    // One clock: source model returns the previous cycle's read, ready is driven.
    task automatic tick();
        logic [7:0] d;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        if (rst) begin
            pend      = 1'b0;
            src_valid = 1'b0;
        end else begin
            src_valid = pend;
            if (pend) begin
                d = 8'($urandom_range(0, 255));
                src_data = d;
                exp_q.push_back({d, pix_idx == 0, (pix_idx % W) == W - 1});
                pix_idx = (pix_idx + 1) % NPIX;
            end
            pend = src_rd_en;
            if (src_rd_en) begin
                check("rd_occupancy", int'((reads_total - xfer_total) < 4), 1);
                rd_cyc_q.push_back(cyc);
                reads_total++;
            end
        end
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            2:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        rd_cyc_q.delete();
        pix_idx     = 0;
        reads_total = 0;
        xfer_total  = 0;
        pend        = 1'b0;
        src_valid   = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int n0;
        int t;
        n0 = fd_count;
        t = 0;
        while (fd_count == n0 && t < budget) begin
            tick();
            t++;
        end
        if (fd_count == n0) begin
            checks++;
            errors++;
            $display("FAIL wait_fd: no frame_done within %0d cycles, got %0d frames expected %0d", budget, fd_count, n0 + 1);
        end
    endtask

    // Monitor: samples after the stimulus has settled, well before the next edge.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            hold_pending = 1'b0;
            frame_pix = 0;
            frame_sof = 0;
            frame_eol = 0;
        end else begin
            if (hold_pending) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_hold", int'({m_data, m_sof, m_eol}), int'(held));
            end
            if (frame_done) begin
                check("fd_pixels", frame_pix, NPIX);
                check("fd_sof_count", frame_sof, 1);
                check("fd_eol_count", frame_eol, H);
                check("fd_queue_empty", exp_q.size(), 0);
                fd_count++;
                fd_cyc = cyc;
                frame_pix = 0;
                frame_sof = 0;
                frame_eol = 0;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0h expected no pixel", {m_data, m_sof, m_eol});
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pixel", int'({m_data, m_sof, m_eol}), int'(exp_e));
                end
                frame_pix++;
                if (m_sof) frame_sof++;
                if (m_eol) frame_eol++;
                xfer_total++;
                last_xfer_cyc = cyc;
            end
            hold_pending = m_valid && !m_ready;
            held = {m_data, m_sof, m_eol};
        end
    end

    initial begin
        int r0;
        int x0;
        int f0;
        int d1;
        int t;

        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Free-flowing frame: read cadence and frame_done latency.
        ready_mode = 0;
        rd_cyc_q.delete();
        start = 1'b1;
        wait_fd(200);
        check("t1_reads", rd_cyc_q.size(), NPIX);
        if (rd_cyc_q.size() == NPIX) begin
            for (int i = 1; i < NPIX; i++)
                check("t1_read_gap", rd_cyc_q[i] - rd_cyc_q[i-1], (i % W == 0) ? HG + 1 : 1);
        end
        check("t1_fd_latency", fd_cyc - last_xfer_cyc, 1);
        tick();
        check("t1_idle", int'(busy), 0);

        // Ready high one cycle in three.
        ready_mode = 1;
        x0 = xfer_total;
        start = 1'b1;
        wait_fd(400);
        check("t2_pixels", xfer_total - x0, NPIX);
        tick();
        check("t2_idle", int'(busy), 0);

        // Sink blocked for 20 cycles: reads stop once the FIFO is committed.
        ready_mode = 2;
        r0 = reads_total;
        x0 = xfer_total;
        start = 1'b1;
        repeat (20) tick();
        check("t3_reads_stalled", reads_total - r0, 4);
        check("t3_rd_en_low", int'(src_rd_en), 0);
        ready_mode = 0;
        wait_fd(200);
        check("t3_pixels", xfer_total - x0, NPIX);
        tick();

        // Continuous mode with inter-frame gap, then stop after frame 2.
        ready_mode = 3;
        continuous = 1'b1;
        start = 1'b1;
        wait_fd(400);
        d1 = fd_cyc;
        rd_cyc_q.delete();
        t = 0;
        while (rd_cyc_q.size() == 0 && t < 20) begin
            tick();
            t++;
        end
        if (rd_cyc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL t4_vgap: no read within 20 cycles of frame_done, got 0 reads expected 1");
        end else begin
            check("t4_vgap", rd_cyc_q[0] - d1, VG);
        end
        repeat (2) tick();
        continuous = 1'b0;
        wait_fd(400);
        tick();
        check("t4_idle", int'(busy), 0);
        r0 = reads_total;
        repeat (10) tick();
        check("t4_no_reads", reads_total - r0, 0);

        // Reset during the second line, then a clean restart.
        ready_mode = 3;
        r0 = reads_total;
        start = 1'b1;
        t = 0;
        while (reads_total - r0 < 6 && t < 100) begin
            tick();
            t++;
        end
        check("t5_reached_line1", int'(reads_total - r0 >= 6), 1);
        do_reset();
        repeat (5) tick();
        check("t5_no_autostart", int'(busy), 0);
        check("t5_no_reads", reads_total, 0);
        start = 1'b1;
        wait_fd(400);
        check("t5_pixels", xfer_total, NPIX);
        tick();

        // Extra start pulses while busy must be ignored.
        for (int f = 0; f < 3; f++) begin
            ready_mode = 3;
            x0 = xfer_total;
            f0 = fd_count;
            start = 1'b1;
            tick();
            t = 0;
            while (fd_count == f0 && t < 400) begin
                if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
                tick();
                t++;
            end
            check("t6_frames", fd_count - f0, 1);
            check("t6_pixels", xfer_total - x0, NPIX);
            tick();
            check("t6_idle", int'(busy), 0);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_src_ctrl.md
IMG_SRC_CTRL -- requirements
Module: img_src_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 640: pixels per line, range 2..4095.
REQ-003 The block SHALL have parameter IMG_H, default 480: lines per frame, range 1..4095.
REQ-004 The block SHALL have parameter H_GAP, default 16: idle cycles between lines, range 0..255.
REQ-005 The block SHALL have parameter V_GAP, default 64: idle cycles between frames in continuous mode, range 0..65535.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins a frame.
REQ-009 The block SHALL have port continuous, input, 1 bit: repeat frames until cleared; sampled at end of frame.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port src_rd_en, output, 1 bit: read request to the byte source.
REQ-012 The block SHALL have port src_valid, input, 1 bit: source data valid, exactly 1 cycle after src_rd_en.
REQ-013 The block SHALL have port src_data, input, DATA_WIDTH bits: source data.
REQ-014 The block SHALL have ports m_data (output, DATA_WIDTH bits), m_valid (output, 1 bit) and m_ready (input, 1 bit): output pixel stream.
REQ-015 The block SHALL have ports m_sof (output, 1 bit, first pixel of frame) and m_eol (output, 1 bit, last pixel of line).
REQ-016 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the frame's last pixel is accepted.

Function
REQ-017 The block SHALL contain a 4-entry FIFO of {data, sof, eol}; output is FIFO head; m_valid = FIFO not empty.
REQ-018 A transfer SHALL occur when m_valid && m_ready; m_data/m_sof/m_eol SHALL hold while m_valid && !m_ready.
REQ-019 src_rd_en SHALL assert only in state LINE and only when (FIFO occupancy + reads in flight) < 4, so source data is never dropped.
REQ-020 Each src_valid beat SHALL be written to the FIFO tagged with the sof/eol of the read that produced it; a write and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 Issue counters x (0..IMG_W-1) and y (0..IMG_H-1) SHALL advance on each src_rd_en; sof tag = (x==0 && y==0); eol tag = (x==IMG_W-1).
REQ-022 States SHALL be IDLE, LINE, HGAP, DRAIN and VGAP.
REQ-023 IDLE->LINE on start; x and y SHALL clear.
REQ-024 LINE->HGAP on the read with x==IMG_W-1 when y<IMG_H-1; LINE->DRAIN on that read when y==IMG_H-1.
REQ-025 HGAP SHALL count H_GAP cycles then go to LINE with y+1; H_GAP=0 SHALL return to LINE on the next cycle.
REQ-026 DRAIN SHALL wait until FIFO empty and no read in flight, then pulse frame_done for one cycle.
REQ-027 On leaving DRAIN the block SHALL go to VGAP if continuous=1, else to IDLE.
REQ-028 VGAP SHALL count V_GAP cycles, then go to LINE with x and y cleared.
REQ-029 start SHALL be ignored when not in IDLE.
REQ-030 Exactly IMG_W*IMG_H pixels SHALL be emitted per frame, with exactly one m_sof and IMG_H m_eol pulses.

Reset
REQ-031 While rst=1: state=IDLE; FIFO empty; counters 0; outputs busy, src_rd_en, m_valid, m_sof, m_eol and frame_done=0; m_data=0.
REQ-032 Reset asserted mid-frame SHALL discard in-flight and buffered data; the next frame SHALL start only on a new start pulse.

Verification
REQ-033 IMG_W=4, IMG_H=2, H_GAP=2, m_ready=1, start -> 8 pixels in source order; m_sof on pixel 0; m_eol on pixels 3 and 7; 2 idle read cycles between lines; frame_done 1 cycle after pixel 7.
REQ-034 Same setup with m_ready toggling 1-in-3 -> no data lost or duplicated; src_rd_en never issued with occupancy+in-flight=4; m_data stable during stalls.
REQ-035 m_ready=0 for 20 cycles after start -> exactly 4 reads issued, then src_rd_en low until m_ready rises; all 8 pixels delivered in order.
REQ-036 continuous=1, V_GAP=3 -> second frame's first read exactly 3 cycles after frame_done; clearing continuous during frame 2 -> IDLE after frame 2's frame_done.
REQ-037 rst pulsed during line 1 -> all outputs 0 in the same cycle; start pulse -> new frame begins with m_sof on pixel 0.
REQ-038 start pulsed while busy -> no effect on counts or sequence.
